// File: rtl/demap_pkg.sv
// Shared types and constants for the demapper frame controller and its bit packer.
package demap_pkg;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   localparam int BPS_MIN = 2;
   localparam int BPS_MAX = 5;
   localparam int ACC_W   = 16;
   localparam int BYTE_W  = 8;
   localparam int CNT_W   = 5;

   function automatic logic bps_legal(input logic [2:0] bps);
      return (bps >= 3'(BPS_MIN)) && (bps <= 3'(BPS_MAX));
   endfunction

endpackage

// File: rtl/demap_bit_packer.sv
// Left-aligned bit accumulator that packs variable-width demapper results MSB-first
// into bytes, zero-pads the frame tail and owns the byte output register.
module demap_bit_packer
   import demap_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       bps,
   input  logic             append,
   input  logic [4:0]       append_bits,
   input  logic             final_phase,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [7:0]       out_byte,
   output logic             out_last,
   output logic [CNT_W-1:0] acc_cnt
);

   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
   logic              out_valid_q, out_valid_d;
   logic [BYTE_W-1:0] out_byte_q, out_byte_d;
   logic              out_last_q, out_last_d;

   logic              out_free, drain, pad, load;
   logic [ACC_W-1:0]  base_acc, ext;
   logic [CNT_W-1:0]  base_cnt, shamt;
   logic [4:0]        masked;

   always_comb begin
      out_free = !out_valid_q || out_ready;
      drain    = out_free && (acc_cnt_q >= 5'(BYTE_W));
      pad      = out_free && final_phase && (acc_cnt_q != '0) && (acc_cnt_q < 5'(BYTE_W));
      load     = drain || pad;

      // Drain happens before the append so both can share one cycle.
      base_acc = load ? (acc_q << BYTE_W) : acc_q;
      base_cnt = drain ? (acc_cnt_q - 5'(BYTE_W)) : (pad ? '0 : acc_cnt_q);

      masked   = append_bits & ((5'd1 << bps) - 5'd1);
      shamt    = 5'(ACC_W) - {2'b00, bps} - base_cnt;
      ext      = {{(ACC_W-5){1'b0}}, masked} << shamt;

      acc_d     = append ? (base_acc | ext) : base_acc;
      acc_cnt_d = base_cnt + (append ? {2'b00, bps} : '0);

      out_valid_d = out_valid_q;
      out_byte_d  = out_byte_q;
      out_last_d  = out_last_q;
      if (load) begin
         out_valid_d = 1'b1;
         out_byte_d  = acc_q[ACC_W-1 -: BYTE_W];
         out_last_d  = final_phase && (base_cnt == '0);
      end else if (out_ready) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q       <= '0;
         acc_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         out_byte_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         acc_cnt_q   <= acc_cnt_d;
         out_valid_q <= out_valid_d;
         out_byte_q  <= out_byte_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_byte  = out_byte_q;
   assign out_last  = out_last_q;
   assign acc_cnt   = acc_cnt_q;

endmodule

// File: rtl/demap_frame_ctrl.sv
// Frame controller: latches per-frame config, issues symbols to the demapper under
// accumulator back-pressure and hands the returned bits to the byte packer.
module demap_frame_ctrl
   import demap_pkg::*;
#(
   parameter int NSYM_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [2:0]        cfg_bps,
   input  logic [3:0]        cfg_rate,
   input  logic [NSYM_W-1:0] cfg_nsym,
   input  logic              sym_valid,
   output logic              sym_ready,
   input  logic [15:0]       sym_real,
   input  logic [15:0]       sym_imag,
   output logic              dm_enable,
   output logic [15:0]       dm_real,
   output logic [15:0]       dm_imag,
   output logic [3:0]        dm_rate,
   input  logic [4:0]        dm_bits,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_byte,
   output logic              out_last,
   output logic              busy,
   output logic              err_cfg
);

   state_t            state_q, state_d;
   logic [2:0]        bps_q, bps_d;
   logic [3:0]        rate_q, rate_d;
   logic [NSYM_W-1:0] issue_cnt_q, issue_cnt_d;
   logic              inflight_q, inflight_d;
   logic              err_cfg_q, err_cfg_d;

   logic [CNT_W-1:0]  acc_cnt;
   logic [6:0]        need_cnt;
   logic              accept, final_phase;

   // Space check counts the pending result as already stored, ignoring any same-cycle drain.
   always_comb begin
      need_cnt = 7'(acc_cnt) + (inflight_q ? 7'(bps_q) : 7'd0) + 7'(bps_q);

      state_d     = state_q;
      bps_d       = bps_q;
      rate_d      = rate_q;
      issue_cnt_d = issue_cnt_q;
      inflight_d  = 1'b0;
      err_cfg_d   = 1'b0;
      cfg_ready   = 1'b0;
      sym_ready   = 1'b0;
      accept      = 1'b0;

      case (state_q)
         IDLE: begin
            cfg_ready = !rst;
            if (cfg_valid) begin
               bps_d  = cfg_bps;
               rate_d = cfg_rate;
               if (!bps_legal(cfg_bps) || (cfg_nsym == '0)) begin
                  err_cfg_d = 1'b1;
               end else begin
                  issue_cnt_d = cfg_nsym;
                  state_d     = RUN;
               end
            end
         end
         RUN: begin
            sym_ready  = (issue_cnt_q != '0) && (need_cnt <= 7'(ACC_W));
            accept     = sym_valid && sym_ready;
            inflight_d = accept;
            if (accept) begin
               issue_cnt_d = issue_cnt_q - 1'b1;
            end
            if ((issue_cnt_q == '0) && !inflight_q) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (out_valid && out_ready && out_last) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         bps_q       <= '0;
         rate_q      <= '0;
         issue_cnt_q <= '0;
         inflight_q  <= 1'b0;
         err_cfg_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         bps_q       <= bps_d;
         rate_q      <= rate_d;
         issue_cnt_q <= issue_cnt_d;
         inflight_q  <= inflight_d;
         err_cfg_q   <= err_cfg_d;
      end
   end

   // No more bits will arrive once every symbol is issued and its result collected.
   assign final_phase = (state_q == FLUSH) ||
                        ((state_q == RUN) && (issue_cnt_q == '0) && !inflight_q);

   demap_bit_packer u_packer (
      .clk         (clk),
      .rst         (rst),
      .bps         (bps_q),
      .append      (inflight_q),
      .append_bits (dm_bits),
      .final_phase (final_phase),
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .out_byte    (out_byte),
      .out_last    (out_last),
      .acc_cnt     (acc_cnt)
   );

   assign dm_enable = accept;
   assign dm_real   = sym_real;
   assign dm_imag   = sym_imag;
   assign dm_rate   = rate_q;
   assign busy      = (state_q != IDLE);
   assign err_cfg   = err_cfg_q;

endmodule
